i2c_slave: RTL

//  Single-address I2C target that sits on the far end of the bus driven by our i2c master.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_bus_sync.sv | 46 ++++
 rtl/i2c_slave.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-address I2C target.
// Holds the protocol state encoding, bus-level constants and the address compare helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WRITE     = 3'd3,
    WRITE_ACK = 3'd4,
    READ      = 3'd5,
    RD_ACK    = 3'd6
  } i2c_state_e;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam logic [2:0] BIT_CNT_MSB = 3'd7;

  // Address byte is {addr[6:0], rw}; general call and 10-bit headers simply fail this compare.
  function automatic logic addr_match(input logic [7:0] addr_rw, input logic [6:0] addr);
    return (addr_rw[7:1] == addr);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and derives edge and START/STOP events.
// Chains reset to 1 so an idle (pulled-up) bus produces no spurious events out of reset.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_prev_r;
  logic                   sda_prev_r;
  logic                   scl_cur;

  // Synchroniser chains plus one history flop per line for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_prev_r <= scl_sync_r[SYNC_STAGES-1];
      sda_prev_r <= sda_sync_r[SYNC_STAGES-1];
    end
  end

  assign scl_cur   = scl_sync_r[SYNC_STAGES-1];
  assign sda_s     = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise  = scl_cur & ~scl_prev_r;
  assign scl_fall  = ~scl_cur & scl_prev_r;
  // SCL must be high in both samples so an SDA change at an SCL edge is not taken as a condition.
  assign start_det = scl_cur & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_det  = scl_cur & scl_prev_r & ~sda_prev_r & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target without clock stretching: FSM, bit counter, shift register
// and the open-drain SDA drive flop, fed by the oversampling bus synchroniser.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addressed,
  output logic       busy
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  i2c_state_e state_r, state_nxt;
  logic [2:0] bit_cnt_r, bit_cnt_nxt;
  logic [7:0] shift_r, shift_nxt;
  logic       drive_r, drive_nxt;
  logic       phase_r, phase_nxt;
  logic       rw_r, rw_nxt;
  logic [7:0] rx_data_r, rx_data_nxt;
  logic       rx_pend_r, rx_pend_nxt;
  logic       rx_valid_r, rx_valid_nxt;
  logic       tx_load_r, tx_load_nxt;
  logic       addressed_r, addressed_nxt;
  logic       busy_r, busy_nxt;
  logic [7:0] rx_byte;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  // drive_r = 1 pulls the line low; the line is never driven high.
  assign sda       = drive_r ? 1'b0 : 1'bz;
  assign rx_byte   = {shift_r[6:0], sda_s};
  assign tx_load   = tx_load_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign addressed = addressed_r;
  assign busy      = busy_r;

  // State and datapath registers; async clear also releases SDA immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= BIT_CNT_MSB;
      shift_r     <= 8'h00;
      drive_r     <= 1'b0;
      phase_r     <= 1'b0;
      rw_r        <= I2C_RW_WRITE;
      rx_data_r   <= 8'h00;
      rx_pend_r   <= 1'b0;
      rx_valid_r  <= 1'b0;
      tx_load_r   <= 1'b0;
      addressed_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      bit_cnt_r   <= bit_cnt_nxt;
      shift_r     <= shift_nxt;
      drive_r     <= drive_nxt;
      phase_r     <= phase_nxt;
      rw_r        <= rw_nxt;
      rx_data_r   <= rx_data_nxt;
      rx_pend_r   <= rx_pend_nxt;
      rx_valid_r  <= rx_valid_nxt;
      tx_load_r   <= tx_load_nxt;
      addressed_r <= addressed_nxt;
      busy_r      <= busy_nxt;
    end
  end

  // Next-state and datapath updates; START/STOP override all bit-level activity.
  always_comb begin
    state_nxt     = state_r;
    bit_cnt_nxt   = bit_cnt_r;
    shift_nxt     = shift_r;
    drive_nxt     = drive_r;
    phase_nxt     = phase_r;
    rw_nxt        = rw_r;
    rx_data_nxt   = rx_data_r;
    rx_pend_nxt   = 1'b0;
    rx_valid_nxt  = rx_pend_r;
    tx_load_nxt   = 1'b0;
    addressed_nxt = addressed_r;
    busy_nxt      = busy_r;

    if (start_det) begin
      state_nxt     = ADDR;
      bit_cnt_nxt   = BIT_CNT_MSB;
      busy_nxt      = 1'b1;
      addressed_nxt = 1'b0;
      drive_nxt     = 1'b0;
      phase_nxt     = 1'b0;
    end else if (stop_det) begin
      state_nxt     = IDLE;
      busy_nxt      = 1'b0;
      addressed_nxt = 1'b0;
      drive_nxt     = 1'b0;
      phase_nxt     = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          drive_nxt = 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            shift_nxt = rx_byte;
            if (bit_cnt_r == 3'd0) begin
              phase_nxt = 1'b0;
              if (addr_match(rx_byte, SLAVE_ADDR)) begin
                state_nxt = ADDR_ACK;
                rw_nxt    = rx_byte[0];
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              bit_cnt_nxt = bit_cnt_r - 3'd1;
            end
          end else begin
            state_nxt = ADDR;
          end
        end

        // phase_r separates the fall that starts the ACK bit from the fall that ends it.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_r) begin
              drive_nxt     = 1'b1;
              addressed_nxt = 1'b1;
              phase_nxt     = 1'b1;
            end else begin
              phase_nxt   = 1'b0;
              bit_cnt_nxt = BIT_CNT_MSB;
              if (rw_r == I2C_RW_READ) begin
                tx_load_nxt = 1'b1;
                shift_nxt   = {tx_data[6:0], 1'b0};
                drive_nxt   = ~tx_data[7];
                state_nxt   = READ;
              end else begin
                drive_nxt = 1'b0;
                state_nxt = WRITE;
              end
            end
          end else begin
            state_nxt = ADDR_ACK;
          end
        end

        WRITE: begin
          if (scl_rise) begin
            shift_nxt = rx_byte;
            if (bit_cnt_r == 3'd0) begin
              rx_data_nxt = rx_byte;
              rx_pend_nxt = 1'b1;
              phase_nxt   = 1'b0;
              state_nxt   = WRITE_ACK;
            end else begin
              bit_cnt_nxt = bit_cnt_r - 3'd1;
            end
          end else begin
            state_nxt = WRITE;
          end
        end

        WRITE_ACK: begin
          if (scl_fall) begin
            if (!phase_r) begin
              drive_nxt = 1'b1;
              phase_nxt = 1'b1;
            end else begin
              drive_nxt   = 1'b0;
              phase_nxt   = 1'b0;
              bit_cnt_nxt = BIT_CNT_MSB;
              state_nxt   = WRITE;
            end
          end else begin
            state_nxt = WRITE_ACK;
          end
        end

        // Bit 7 is already on the line at entry; each fall presents the next bit.
        READ: begin
          if (scl_fall) begin
            if (bit_cnt_r == 3'd0) begin
              drive_nxt = 1'b0;
              phase_nxt = 1'b0;
              state_nxt = RD_ACK;
            end else begin
              drive_nxt   = ~shift_r[7];
              shift_nxt   = {shift_r[6:0], 1'b0};
              bit_cnt_nxt = bit_cnt_r - 3'd1;
            end
          end else begin
            state_nxt = READ;
          end
        end

        RD_ACK: begin
          if (scl_rise && !phase_r) begin
            if (sda_s == I2C_NACK) begin
              state_nxt     = IDLE;
              addressed_nxt = 1'b0;
              drive_nxt     = 1'b0;
            end else begin
              phase_nxt = 1'b1;
            end
          end else if (scl_fall && phase_r) begin
            tx_load_nxt = 1'b1;
            shift_nxt   = {tx_data[6:0], 1'b0};
            drive_nxt   = ~tx_data[7];
            bit_cnt_nxt = BIT_CNT_MSB;
            phase_nxt   = 1'b0;
            state_nxt   = READ;
          end else begin
            state_nxt = RD_ACK;
          end
        end

        default: begin
          state_nxt = IDLE;
          drive_nxt = 1'b0;
          phase_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule
